// File: rtl/sgr_encoder.sv
// sgr_encoder: serialises a graphics-state snapshot (fg/bg RGB333 plus four
// effect bits) as an ANSI SGR escape sequence, one byte per transfer on a
// valid/ready byte stream.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start
// ESC       | emitting 8'h1B
// LBR       | emitting '['
// ZERO      | emitting '0' (reset-all attribute)
// ATTR      | emitting ";<n>" for each set effect flag (attr_pos selects char)
// HDR       | emitting ";38;2" (fg) or ";48;2" (bg), hdr_idx selects char
// COMP_SEMI | emitting ';' before a colour component
// COMP_D2   | emitting hundreds digit
// COMP_D1   | emitting tens digit
// COMP_D0   | emitting units digit
// TERM      | emitting 'm'
// FIN       | done pulse; a start here is accepted
`timescale 1ns/1ps
module sgr_encoder #(
    parameter logic [8:0] DEFAULT_FG = 9'h16D,
    parameter logic [8:0] DEFAULT_BG = 9'h000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] fg,
    input  logic [8:0] bg,
    input  logic       underline,
    input  logic       blink,
    input  logic       negative,
    input  logic       bright,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE, ESC, LBR, ZERO, ATTR, HDR, COMP_SEMI,
        COMP_D2, COMP_D1, COMP_D0, TERM, FIN
    } state_t;

    state_t     state, state_nxt;
    logic [8:0] snap_fg, snap_bg;
    // [0]=bright [1]=underline [2]=blink [3]=negative, i.e. emission order
    logic [3:0] snap_flags;
    logic [1:0] flag_idx, flag_idx_nxt;
    logic       attr_pos, attr_pos_nxt;
    logic [2:0] hdr_idx, hdr_idx_nxt;
    logic       blk_bg, blk_bg_nxt;
    logic [1:0] comp_idx, comp_idx_nxt;

    logic       accept;
    logic       xfer;
    logic       fg_custom, bg_custom;
    logic       flag_found;
    logic [1:0] flag_next;
    state_t     sec_state;
    logic       sec_blk;
    logic [8:0] comp_col;
    logic [2:0] comp_c;
    logic [7:0] comp_v;
    logic [1:0] hund;
    logic [7:0] rem;
    logic [3:0] tens;
    logic [7:0] tens_sub;
    logic [3:0] units;
    logic [7:0] hdr_char;
    logic [7:0] flag_char;

    assign accept    = start && ((state == IDLE) || (state == FIN));
    assign xfer      = out_valid && out_ready;
    assign fg_custom = (snap_fg != DEFAULT_FG);
    assign bg_custom = (snap_bg != DEFAULT_BG);

    // Next set effect flag: from index 0 when leaving ZERO, otherwise above the current one
    always_comb begin
        flag_found = 1'b0;
        flag_next  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (snap_flags[k] && ((state == ZERO) || (3'(k) > {1'b0, flag_idx}))) begin
                flag_found = 1'b1;
                flag_next  = 2'(k);
            end
        end
    end

    // Where the stream goes once the effect flags are exhausted
    always_comb begin
        sec_state = TERM;
        sec_blk   = 1'b0;
        if (fg_custom) begin
            sec_state = HDR;
            sec_blk   = 1'b0;
        end else if (bg_custom) begin
            sec_state = HDR;
            sec_blk   = 1'b1;
        end
    end

    // Current colour component expanded to 8 bits and split into decimal digits
    always_comb begin
        comp_col = blk_bg ? snap_bg : snap_fg;
        case (comp_idx)
            2'd0:    comp_c = comp_col[8:6];
            2'd1:    comp_c = comp_col[5:3];
            default: comp_c = comp_col[2:0];
        endcase
        comp_v = {comp_c, comp_c, comp_c[2:1]};
        if (comp_v >= 8'd200) begin
            hund = 2'd2;
            rem  = comp_v - 8'd200;
        end else if (comp_v >= 8'd100) begin
            hund = 2'd1;
            rem  = comp_v - 8'd100;
        end else begin
            hund = 2'd0;
            rem  = comp_v;
        end
        tens     = 4'd0;
        tens_sub = 8'd0;
        for (int k = 1; k < 10; k++) begin
            if (rem >= 8'(k * 10)) begin
                tens     = 4'(k);
                tens_sub = 8'(k * 10);
            end
        end
        units = 4'(rem - tens_sub);
    end

    // Character lookups for the colour header and the effect codes
    always_comb begin
        case (hdr_idx)
            3'd0:    hdr_char = 8'h3B;
            3'd1:    hdr_char = blk_bg ? 8'h34 : 8'h33;
            3'd2:    hdr_char = 8'h38;
            3'd3:    hdr_char = 8'h3B;
            default: hdr_char = 8'h32;
        endcase
        case (flag_idx)
            2'd0:    flag_char = 8'h31;
            2'd1:    flag_char = 8'h34;
            2'd2:    flag_char = 8'h35;
            default: flag_char = 8'h37;
        endcase
    end

    // Next-state and stream outputs; every state advances only on a transfer
    always_comb begin
        state_nxt    = state;
        flag_idx_nxt = flag_idx;
        attr_pos_nxt = attr_pos;
        hdr_idx_nxt  = hdr_idx;
        blk_bg_nxt   = blk_bg;
        comp_idx_nxt = comp_idx;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ESC;
            end
            ESC: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h1B;
                if (xfer) state_nxt = LBR;
            end
            LBR: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h5B;
                if (xfer) state_nxt = ZERO;
            end
            ZERO: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h30;
                if (xfer) begin
                    if (flag_found) begin
                        state_nxt    = ATTR;
                        flag_idx_nxt = flag_next;
                        attr_pos_nxt = 1'b0;
                    end else begin
                        state_nxt   = sec_state;
                        blk_bg_nxt  = sec_blk;
                        hdr_idx_nxt = 3'd0;
                    end
                end
            end
            ATTR: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = attr_pos ? flag_char : 8'h3B;
                if (xfer) begin
                    if (!attr_pos) begin
                        attr_pos_nxt = 1'b1;
                    end else if (flag_found) begin
                        flag_idx_nxt = flag_next;
                        attr_pos_nxt = 1'b0;
                    end else begin
                        state_nxt   = sec_state;
                        blk_bg_nxt  = sec_blk;
                        hdr_idx_nxt = 3'd0;
                    end
                end
            end
            HDR: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = hdr_char;
                if (xfer) begin
                    if (hdr_idx == 3'd4) begin
                        state_nxt    = COMP_SEMI;
                        comp_idx_nxt = 2'd0;
                    end else begin
                        hdr_idx_nxt = hdr_idx + 3'd1;
                    end
                end
            end
            COMP_SEMI: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h3B;
                if (xfer) begin
                    if (hund != 2'd0)      state_nxt = COMP_D2;
                    else if (tens != 4'd0) state_nxt = COMP_D1;
                    else                   state_nxt = COMP_D0;
                end
            end
            COMP_D2: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h30 + {6'd0, hund};
                if (xfer) state_nxt = COMP_D1;
            end
            COMP_D1: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h30 + {4'd0, tens};
                if (xfer) state_nxt = COMP_D0;
            end
            COMP_D0: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h30 + {4'd0, units};
                if (xfer) begin
                    if (comp_idx != 2'd2) begin
                        state_nxt    = COMP_SEMI;
                        comp_idx_nxt = comp_idx + 2'd1;
                    end else if (!blk_bg && bg_custom) begin
                        state_nxt   = HDR;
                        blk_bg_nxt  = 1'b1;
                        hdr_idx_nxt = 3'd0;
                    end else begin
                        state_nxt = TERM;
                    end
                end
            end
            TERM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = 8'h6D;
                if (xfer) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = start ? ESC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, walk indices and the input snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snap_fg    <= 9'd0;
            snap_bg    <= 9'd0;
            snap_flags <= 4'd0;
            flag_idx   <= 2'd0;
            attr_pos   <= 1'b0;
            hdr_idx    <= 3'd0;
            blk_bg     <= 1'b0;
            comp_idx   <= 2'd0;
        end else begin
            state    <= state_nxt;
            flag_idx <= flag_idx_nxt;
            attr_pos <= attr_pos_nxt;
            hdr_idx  <= hdr_idx_nxt;
            blk_bg   <= blk_bg_nxt;
            comp_idx <= comp_idx_nxt;
            if (accept) begin
                snap_fg    <= fg;
                snap_bg    <= bg;
                snap_flags <= {negative, blink, underline, bright};
            end
        end
    end

endmodule

// File: tb/tb_sgr_encoder.sv
// tb_sgr_encoder: directed vectors for the SGR encoder with hand-written
// expected byte streams, plus reset-abort and back-to-back start sequences.
`timescale 1ns/1ps
module tb_sgr_encoder;

    localparam logic [8:0] DEF_FG = 9'h16D;
    localparam logic [8:0] DEF_BG = 9'h000;

    logic       clk, rst, start;
    logic [8:0] fg, bg;
    logic       underline, blink, negative, bright;
    logic [7:0] out_data;
    logic       out_valid, out_ready, busy, done;

    sgr_encoder #(.DEFAULT_FG(DEF_FG), .DEFAULT_BG(DEF_BG)) dut (
        .clk(clk), .rst(rst), .start(start), .fg(fg), .bg(bg),
        .underline(underline), .blink(blink), .negative(negative), .bright(bright),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] fg;
        logic [8:0] bg;
        logic       bright;
        logic       underline;
        logic       blink;
        logic       negative;
        logic       rnd_ready;
        logic       inject;
        logic [5:0] exp_len;
    } vec_t;

    localparam int NV = 7;
    vec_t  vecs  [NV];
    string exp_s [NV];   // expected stream after the leading 8'h1B

    int tests = 0;
    int fails = 0;

    logic [7:0] cap [0:63];
    int cap_n, cap_cyc, cap_busy, cap_unstable, cap_done_seen;

    task automatic check(input bit ok, input string name, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic do_start(input int i);
        fg        = vecs[i].fg;
        bg        = vecs[i].bg;
        bright    = vecs[i].bright;
        underline = vecs[i].underline;
        blink     = vecs[i].blink;
        negative  = vecs[i].negative;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Collect bytes until done is seen; called at a negedge with the stream running
    task automatic capture(input bit rnd, input bit inject);
        bit         held;
        logic [7:0] held_d;
        bit         rdy;
        cap_n = 0; cap_cyc = 0; cap_busy = 0; cap_unstable = 0; cap_done_seen = 0;
        held = 1'b0; held_d = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                cap_done_seen = 1;
                if (out_valid || busy) cap_unstable++;
                break;
            end
            if (held && out_valid && (out_data != held_d)) cap_unstable++;
            if (busy) cap_busy++;
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready = rdy;
            start = inject && busy && ($urandom_range(0, 2) == 0);
            if (start) begin
                fg = 9'($urandom);
                bg = 9'($urandom);
                {bright, underline, blink, negative} = 4'($urandom);
            end
            if (out_valid && rdy) begin
                if (cap_n < 64) cap[cap_n] = out_data;
                cap_n++;
                held = 1'b0;
            end else if (out_valid) begin
                held   = 1'b1;
                held_d = out_data;
            end
            cap_cyc++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Independent SGR parse of the captured bytes back into a graphics state
    task automatic decode(output logic [8:0] dfg, output logic [8:0] dbg,
                          output logic [3:0] dfl, output bit ok);
        int nums[$];
        int acc;
        int k;
        logic [31:0] r, g, b;
        dfg = DEF_FG; dbg = DEF_BG; dfl = 4'd0; ok = 1'b1; acc = 0;
        for (int j = 2; j < cap_n && j < 64; j++) begin
            if (cap[j] >= 8'h30 && cap[j] <= 8'h39) acc = acc * 10 + int'(cap[j]) - 48;
            else begin
                nums.push_back(acc);
                acc = 0;
            end
        end
        if (nums.size() == 0) ok = 1'b0;
        else if (nums[0] != 0) ok = 1'b0;
        k = 1;
        while (k < nums.size()) begin
            case (nums[k])
                1: begin dfl[3] = 1'b1; k++; end
                4: begin dfl[2] = 1'b1; k++; end
                5: begin dfl[1] = 1'b1; k++; end
                7: begin dfl[0] = 1'b1; k++; end
                38, 48: begin
                    if ((k + 4 < nums.size()) && (nums[k+1] == 2)) begin
                        r = nums[k+2]; g = nums[k+3]; b = nums[k+4];
                        if (nums[k] == 38) dfg = {r[7:5], g[7:5], b[7:5]};
                        else               dbg = {r[7:5], g[7:5], b[7:5]};
                        k += 5;
                    end else begin
                        ok = 1'b0;
                        k  = nums.size();
                    end
                end
                default: begin
                    ok = 1'b0;
                    k  = nums.size();
                end
            endcase
        end
    endtask

    task automatic check_stream(input int i);
        int         mism;
        logic [8:0] dfg, dbg;
        logic [3:0] dfl;
        bit         dok;
        check(cap_done_seen == 1, $sformatf("v%0d done_seen", i), cap_done_seen, 1);
        check(cap_n == int'(vecs[i].exp_len), $sformatf("v%0d length", i), cap_n, int'(vecs[i].exp_len));
        mism = -1;
        if (cap_n > 0 && cap[0] != 8'h1B) mism = 0;
        for (int k = 1; k < cap_n && k < 64; k++) begin
            if (mism < 0 && (k - 1) < exp_s[i].len())
                if (cap[k] != 8'(exp_s[i].getc(k - 1))) mism = k;
        end
        check(mism < 0, $sformatf("v%0d bytes first_bad_index", i), mism, -1);
        check(cap_unstable == 0, $sformatf("v%0d hold_stable", i), cap_unstable, 0);
        if (!vecs[i].rnd_ready) begin
            check(cap_cyc == cap_n, $sformatf("v%0d no_bubbles cycles", i), cap_cyc, cap_n);
            check(cap_busy == int'(vecs[i].exp_len), $sformatf("v%0d busy_cycles", i),
                  cap_busy, int'(vecs[i].exp_len));
        end
        decode(dfg, dbg, dfl, dok);
        check(dok, $sformatf("v%0d parse_ok", i), int'(dok), 1);
        check(dfg == vecs[i].fg, $sformatf("v%0d decoded_fg", i), int'(dfg), int'(vecs[i].fg));
        check(dbg == vecs[i].bg, $sformatf("v%0d decoded_bg", i), int'(dbg), int'(vecs[i].bg));
        check(dfl == {vecs[i].bright, vecs[i].underline, vecs[i].blink, vecs[i].negative},
              $sformatf("v%0d decoded_flags", i), int'(dfl),
              int'({vecs[i].bright, vecs[i].underline, vecs[i].blink, vecs[i].negative}));
    endtask

    task automatic run_vec(input int i);
        do_start(i);
        capture(vecs[i].rnd_ready, vecs[i].inject);
        check_stream(i);
        @(negedge clk);
        check(done == 1'b0, $sformatf("v%0d done_one_cycle", i), int'(done), 0);
    endtask

    initial begin
        int stray;
        //            fg      bg      br ul bl ng rnd inj len
        vecs[0] = '{9'h16D, 9'h000, 0, 0, 0, 0, 0, 0, 6'd4};
        exp_s[0] = "[0m";
        vecs[1] = '{9'h16D, 9'h000, 1, 1, 0, 1, 0, 0, 6'd10};
        exp_s[1] = "[0;1;4;7m";
        vecs[2] = '{9'h1C5, 9'h000, 0, 0, 0, 0, 0, 0, 6'd19};
        exp_s[2] = "[0;38;2;255;0;182m";
        vecs[3] = '{9'h16D, 9'h053, 0, 0, 0, 0, 0, 0, 6'd19};
        exp_s[3] = "[0;48;2;36;73;109m";
        vecs[4] = '{9'h1FF, 9'h124, 1, 1, 1, 1, 0, 0, 6'd46};
        exp_s[4] = "[0;1;4;5;7;38;2;255;255;255;48;2;146;146;146m";
        vecs[5] = '{9'h000, 9'h1FF, 0, 0, 1, 0, 0, 0, 6'd34};
        exp_s[5] = "[0;5;38;2;0;0;0;48;2;255;255;255m";
        vecs[6] = '{9'h1FF, 9'h124, 1, 1, 1, 1, 1, 1, 6'd46};
        exp_s[6] = "[0;1;4;5;7;38;2;255;255;255;48;2;146;146;146m";

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        fg = 9'd0; bg = 9'd0; underline = 0; blink = 0; negative = 0; bright = 0;
        repeat (3) @(negedge clk);
        check(out_valid == 1'b0, "reset out_valid", int'(out_valid), 0);
        check(out_data == 8'h00, "reset out_data", int'(out_data), 0);
        check(busy == 1'b0, "reset busy", int'(busy), 0);
        check(done == 1'b0, "reset done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Start in the FIN cycle is accepted and the next stream begins at once
        do_start(0);
        capture(1'b0, 1'b0);
        check_stream(0);
        fg = vecs[1].fg; bg = vecs[1].bg;
        {bright, underline, blink, negative} =
            {vecs[1].bright, vecs[1].underline, vecs[1].blink, vecs[1].negative};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check(out_valid == 1'b1, "fin_start out_valid", int'(out_valid), 1);
        check(out_data == 8'h1B, "fin_start out_data", int'(out_data), 8'h1B);
        capture(1'b0, 1'b0);
        check_stream(1);
        @(negedge clk);

        // Reset after five bytes of a long stream aborts it without a done pulse
        out_ready = 1'b1;
        do_start(4);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "abort out_valid", int'(out_valid), 0);
        check(busy == 1'b0, "abort busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || out_valid || busy) stray++;
            @(negedge clk);
        end
        check(stray == 0, "abort quiet_after_reset", stray, 0);
        run_vec(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
